// File: rtl/hdmi_timing_pkg.sv
// Shared constants, sync-bus bit positions and FSM encoding for the HDMI timing controller.
package hdmi_timing_pkg;

    // 1280x720p60 timing
    localparam int H_ACTIVE_720P = 1280;
    localparam int H_FP_720P     = 110;
    localparam int H_SYNC_720P   = 40;
    localparam int H_BP_720P     = 220;
    localparam int V_ACTIVE_720P = 720;
    localparam int V_FP_720P     = 5;
    localparam int V_SYNC_720P   = 5;
    localparam int V_BP_720P     = 20;

    localparam int X_W = 11;
    localparam int Y_W = 10;

    // Bit positions inside the {de, vsync, hsync} bus
    localparam int DE = 2;
    localparam int VS = 1;
    localparam int HS = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/hdmi_timing_ctrl_sync_delay_line.sv
// Fixed-depth shift register that resets to a caller-chosen "blank" word.
module sync_delay_line #(
    parameter int               DEPTH   = 2,
    parameter int               WIDTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [DEPTH-1:0][WIDTH-1:0] r_sr;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_sr <= {DEPTH{RST_VAL}};
        end else begin
            r_sr[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                r_sr[i] <= r_sr[i-1];
            end
        end
    end

    assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/hdmi_timing_ctrl.sv
// Video timing controller: raster counters, pixel-fetch requests, latency-matched
// sync/DE and pixel output, frame-boundary start/stop and underflow flag.
module hdmi_timing_ctrl
    import hdmi_timing_pkg::*;
#(
    parameter int          H_ACTIVE = H_ACTIVE_720P,
    parameter int          H_FP     = H_FP_720P,
    parameter int          H_SYNC   = H_SYNC_720P,
    parameter int          H_BP     = H_BP_720P,
    parameter int          V_ACTIVE = V_ACTIVE_720P,
    parameter int          V_FP     = V_FP_720P,
    parameter int          V_SYNC   = V_SYNC_720P,
    parameter int          V_BP     = V_BP_720P,
    parameter logic        HS_POL   = 1'b1,
    parameter logic        VS_POL   = 1'b1,
    parameter int          PIPE_LAT = 2,
    parameter logic [23:0] UF_COLOR = 24'hFF00FF
) (
    input  logic           i_hdmi_clk,
    input  logic           i_reset_n,
    input  logic           i_enable,
    input  logic           i_clear_underflow,
    input  logic [23:0]    i_rgb,
    input  logic           i_rgb_valid,
    output logic           o_pix_req,
    output logic [X_W-1:0] o_x,
    output logic [Y_W-1:0] o_y,
    output logic           o_frame_start,
    output logic [2:0]     o_hve_sync,
    output logic [23:0]    o_rgb,
    output logic           o_running,
    output logic           o_underflow
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [X_W-1:0] HL_ACT    = X_W'(H_ACTIVE);
    localparam logic [X_W-1:0] HL_SYNC_S = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0] HL_SYNC_E = X_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [X_W-1:0] HL_LAST   = X_W'(H_TOT - 1);
    localparam logic [Y_W-1:0] VL_ACT    = Y_W'(V_ACTIVE);
    localparam logic [Y_W-1:0] VL_SYNC_S = Y_W'(V_ACTIVE + V_FP);
    localparam logic [Y_W-1:0] VL_SYNC_E = Y_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [Y_W-1:0] VL_LAST   = Y_W'(V_TOT - 1);
    localparam logic [3:0]     DRAIN_LAST = 4'(PIPE_LAT);

    localparam logic [2:0] SYNC_BLANK = {1'b0, ~VS_POL, ~HS_POL};

    state_t         r_state, w_state_nxt;
    logic [3:0]     r_drain_cnt, w_drain_cnt_nxt;
    logic [X_W-1:0] r_h;
    logic [Y_W-1:0] r_v;
    logic           w_run;
    logic           w_frame_end;
    logic           w_req;
    logic [2:0]     w_sync_a;
    logic [2:0]     r_sync_a;
    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;
    logic           r_frame_start;
    logic [2:0]     w_sync_d;
    logic [2:0]     r_hve;
    logic [23:0]    r_rgb;
    logic           r_uf;

    assign w_run       = (r_state == RUN);
    assign w_frame_end = (r_h == HL_LAST) && (r_v == VL_LAST);

    always_ff @(posedge i_hdmi_clk) begin
        if (!i_reset_n) begin
            r_state     <= IDLE;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
        end
    end

    // Stop only at the last clock of a frame, then let the delay line empty.
    always_comb begin
        w_state_nxt     = r_state;
        w_drain_cnt_nxt = r_drain_cnt;
        case (r_state)
            IDLE: begin
                if (i_enable) w_state_nxt = RUN;
            end
            RUN: begin
                if (w_frame_end && !i_enable) begin
                    w_state_nxt     = DRAIN;
                    w_drain_cnt_nxt = '0;
                end
            end
            DRAIN: begin
                if (r_drain_cnt == DRAIN_LAST) w_state_nxt = IDLE;
                else                           w_drain_cnt_nxt = r_drain_cnt + 4'd1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Counters wrap to (0,0) on the last RUN clock, so DRAIN/IDLE hold them at origin.
    always_ff @(posedge i_hdmi_clk) begin
        if (!i_reset_n || !w_run) begin
            r_h <= '0;
            r_v <= '0;
        end else if (r_h == HL_LAST) begin
            r_h <= '0;
            r_v <= (r_v == VL_LAST) ? '0 : r_v + 1'b1;
        end else begin
            r_h <= r_h + 1'b1;
        end
    end

    assign w_req = w_run && (r_h < HL_ACT) && (r_v < VL_ACT);

    always_comb begin
        w_sync_a     = SYNC_BLANK;
        w_sync_a[DE] = w_req;
        if (w_run && (r_h >= HL_SYNC_S) && (r_h < HL_SYNC_E)) w_sync_a[HS] = HS_POL;
        if (w_run && (r_v >= VL_SYNC_S) && (r_v < VL_SYNC_E)) w_sync_a[VS] = VS_POL;
    end

    always_ff @(posedge i_hdmi_clk) begin
        if (!i_reset_n) begin
            r_sync_a      <= SYNC_BLANK;
            r_x           <= '0;
            r_y           <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_sync_a      <= w_sync_a;
            r_frame_start <= w_req && (r_h == '0) && (r_v == '0);
            if (w_req) begin
                r_x <= r_h;
                r_y <= r_v;
            end
        end
    end

    sync_delay_line #(
        .DEPTH   (PIPE_LAT),
        .WIDTH   (3),
        .RST_VAL (SYNC_BLANK)
    ) u_sync_dly (
        .i_clk     (i_hdmi_clk),
        .i_reset_n (i_reset_n),
        .i_d       (r_sync_a),
        .o_q       (w_sync_d)
    );

    // Pixel capture lines up with the delayed DE; a missing pixel is replaced and latched.
    always_ff @(posedge i_hdmi_clk) begin
        if (!i_reset_n) begin
            r_hve <= SYNC_BLANK;
            r_rgb <= '0;
            r_uf  <= 1'b0;
        end else begin
            r_hve <= w_sync_d;
            if (w_sync_d[DE]) r_rgb <= i_rgb_valid ? i_rgb : UF_COLOR;
            else              r_rgb <= '0;
            if (w_sync_d[DE] && !i_rgb_valid) r_uf <= 1'b1;
            else if (i_clear_underflow)       r_uf <= 1'b0;
        end
    end

    assign o_pix_req     = r_sync_a[DE];
    assign o_x           = r_x;
    assign o_y           = r_y;
    assign o_frame_start = r_frame_start;
    assign o_hve_sync    = r_hve;
    assign o_rgb         = r_rgb;
    assign o_running     = (r_state != IDLE);
    assign o_underflow   = r_uf;

endmodule

// File: tb/tb_hdmi_timing_ctrl.sv
// Bench for hdmi_timing_ctrl on a 16x8 raster with a 2-clock source latency.
module tb_hdmi_timing_ctrl;

    localparam int HA = 8, HF = 2, HSW = 3, HB = 3;
    localparam int VA = 4, VF = 1, VSW = 2, VB = 1;
    localparam int LAT = 2;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        clr = 1'b0;
    logic        drop = 1'b0;
    logic [23:0] rgb;
    logic        rgb_valid;
    logic        pix_req;
    logic [10:0] o_x;
    logic [9:0]  o_y;
    logic        fs;
    logic [2:0]  hve;
    logic [23:0] o_rgb;
    logic        running;
    logic        uf;

    int n_checks = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hdmi_timing_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_LAT(LAT), .UF_COLOR(24'hFF00FF)
    ) dut (
        .i_hdmi_clk        (clk),
        .i_reset_n         (rst_n),
        .i_enable          (en),
        .i_clear_underflow (clr),
        .i_rgb             (rgb),
        .i_rgb_valid       (rgb_valid),
        .o_pix_req         (pix_req),
        .o_x               (o_x),
        .o_y               (o_y),
        .o_frame_start     (fs),
        .o_hve_sync        (hve),
        .o_rgb             (o_rgb),
        .o_running         (running),
        .o_underflow       (uf)
    );

    // Source: answers each request two clocks later with {y, x, 5A}
    logic        s0_req = 1'b0, s1_req = 1'b0;
    logic [10:0] s0_x = '0, s1_x = '0;
    logic [9:0]  s0_y = '0, s1_y = '0;
    always @(posedge clk) begin
        s0_req <= pix_req; s0_x <= o_x; s0_y <= o_y;
        s1_req <= s0_req;  s1_x <= s0_x; s1_y <= s0_y;
    end
    assign rgb       = s1_req ? {8'(s1_y), 8'(s1_x), 8'h5A} : 24'h123456;
    assign rgb_valid = !(drop && s1_req && s1_x == 11'd3 && s1_y == 10'd1);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit is_act(int p);
        return p >= 0 && (p % HT) < HA && (p / HT) < VA;
    endfunction

    function automatic logic [2:0] sync_of(int p);
        int h, v;
        if (p < 0) return 3'b000;
        h = p % HT;
        v = p / HT;
        return {is_act(p), (v >= VA + VF && v < VA + VF + VSW), (h >= HA + HF && h < HA + HF + HSW)};
    endfunction

    // Model: raster position scanned each clock (-1 when not running), and its history
    int          hist[LAT+2];
    int          mode = 0, lin = 0, dcnt = 0;
    logic        m_uf = 1'b0;
    logic [23:0] m_rgb = '0;
    logic [10:0] m_x = '0;
    logic [9:0]  m_y = '0;
    bit          started = 1'b0;

    always @(posedge clk) begin
        int scan, p;
        if (!rst_n) begin
            mode = 0; lin = 0; dcnt = 0;
            for (int i = 0; i < LAT + 2; i++) hist[i] = -1;
            m_uf = 1'b0; m_rgb = '0; m_x = '0; m_y = '0;
            started = 1'b1;
        end else begin
            scan = (mode == 1) ? lin : -1;
            for (int i = LAT + 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = scan;
            if (is_act(scan)) begin
                m_x = 11'(scan % HT);
                m_y = 10'(scan / HT);
            end
            p = hist[LAT+1];
            if (is_act(p)) m_rgb = rgb_valid ? {8'(p / HT), 8'(p % HT), 8'h5A} : 24'hFF00FF;
            else           m_rgb = '0;
            if (is_act(p) && !rgb_valid) m_uf = 1'b1;
            else if (clr)                m_uf = 1'b0;
            case (mode)
                0: if (en) begin mode = 1; lin = 0; end
                1: begin
                    if (lin == FRAME - 1 && !en) begin mode = 2; dcnt = 0; end
                    lin = (lin + 1) % FRAME;
                end
                default: begin
                    dcnt++;
                    if (dcnt == LAT + 1) mode = 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("pix_req",     pix_req, is_act(hist[0]));
            chk("frame_start", fs, hist[0] == 0);
            chk("x",           o_x, m_x);
            chk("y",           o_y, m_y);
            chk("hve_sync",    hve, sync_of(hist[LAT+1]));
            chk("rgb",         o_rgb, m_rgb);
            chk("running",     running, mode != 0);
            chk("underflow",   uf, m_uf);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 500000");
        $fatal(1);
    end

    initial begin
        int cnt, c_req, c_de, c_hs, c_vs, c_uf;
        bit found;
        en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_hve", hve, 3'b000);
        chk("rst_req", pix_req, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_req_early", pix_req, 0);
        @(negedge clk);
        chk("first_req", pix_req, 1);
        chk("first_fs", fs, 1);
        chk("first_xy", {o_x, o_y}, 0);

        c_req = 0; c_de = 0; c_hs = 0; c_vs = 0;
        for (int i = 0; i < FRAME; i++) begin
            c_req += int'(pix_req); c_de += int'(hve[2]);
            c_vs += int'(hve[1]);   c_hs += int'(hve[0]);
            @(negedge clk);
        end
        chk("frame_req_count", c_req, 32);
        chk("frame_de_count", c_de, 32);
        chk("frame_hs_count", c_hs, 24);
        chk("frame_vs_count", c_vs, 32);

        drop = 1'b1; c_uf = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (hve[2] && o_rgb == 24'hFF00FF) c_uf++;
            @(negedge clk);
        end
        drop = 1'b0;
        chk("uf_color_count", c_uf, 1);
        chk("uf_sticky", uf, 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("uf_clear", uf, 0);

        drop = 1'b1; clr = 1'b1; found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (hve[2] && o_rgb == 24'hFF00FF) found = 1'b1;
        end
        chk("uf_pixel_seen", found, 1);
        chk("uf_set_wins", uf, 1);
        @(negedge clk);
        chk("uf_clear_after", uf, 0);
        clr = 1'b0; drop = 1'b0;

        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (pix_req && o_x == 11'd5 && o_y == 10'd2) found = 1'b1;
        end
        chk("stop_point_seen", found, 1);
        en = 1'b0; cnt = 0;
        while (running && cnt < 400) begin
            @(negedge clk);
            cnt++;
            if (cnt == 10) en = 1'b1;
            else if (cnt == 11) en = 1'b0;
        end
        chk("stop_clocks", cnt, 93);
        repeat (20) @(negedge clk);
        chk("idle_hve", hve, 3'b000);
        chk("idle_running", running, 0);
        chk("idle_req", pix_req, 0);

        en = 1'b1; found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (pix_req && o_x == 11'd6 && o_y == 10'd3) found = 1'b1;
        end
        chk("reset_point_seen", found, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_req", pix_req, 0);
        chk("mrst_xy", {o_x, o_y}, 0);
        chk("mrst_fs", fs, 0);
        chk("mrst_hve", hve, 3'b000);
        chk("mrst_rgb", o_rgb, 0);
        chk("mrst_running", running, 0);
        chk("mrst_uf", uf, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("restart_req", pix_req, 1);
        chk("restart_fs", fs, 1);
        chk("restart_xy", {o_x, o_y}, 0);
        repeat (40) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
